// File: rtl/ex_stall_controller.sv
// EX-stage stall/flush sequencer: freezes the pipeline around an iterative
// mul/div unit, inserts load-use bubbles and taken-branch squashes.
module ex_stall_controller #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rt,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        EX_MulDiv,
  input  logic        branch_taken,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        ID_Flush,
  output logic        IF_Flush,
  output logic        EX_Flush,
  output logic        md_start,
  output logic        md_step,
  output logic        md_last,
  output logic        md_done,
  output logic [15:0] stall_count
);

  // state   | meaning
  // RUN     | normal flow; load-use bubbles and branch squashes handled here
  // MD_BUSY | mul/div iterating, pipeline frozen, cnt counts down to 0
  // MD_DONE | result on ALU path for one cycle, stalls released
  typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load_use;

  assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    ID_Flush    = 1'b0;
    IF_Flush    = 1'b0;
    EX_Flush    = 1'b0;
    md_start    = 1'b0;
    md_step     = 1'b0;
    md_last     = 1'b0;
    md_done     = 1'b0;
    // Outputs show their idle values for as long as reset is held.
    if (rst_n) begin
      case (state)
        RUN: begin
          if (EX_MulDiv) begin
            md_start    = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            EX_Flush    = 1'b1;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_Flush    = 1'b1;
          end else if (branch_taken) begin
            IF_Flush = 1'b1;
          end
        end
        MD_BUSY: begin
          md_step     = 1'b1;
          PC_Write    = 1'b0;
          IF_ID_Write = 1'b0;
          ID_EX_Write = 1'b0;
          EX_Flush    = 1'b1;
          md_last     = (cnt == '0);
        end
        MD_DONE: begin
          md_done = 1'b1;
          // EX_MulDiv is deliberately ignored here so the finished op cannot restart.
          if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_Flush    = 1'b1;
          end else if (branch_taken) begin
            IF_Flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= 16'd0;
    end else begin
      case (state)
        RUN: begin
          if (EX_MulDiv) begin
            cnt   <= CNT_INIT;
            state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (cnt == '0) state <= MD_DONE;
          else           cnt   <= cnt - 1'b1;
        end
        MD_DONE: state <= RUN;
        default: state <= RUN;
      endcase
      if (!PC_Write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_stall_controller.sv
// Scoreboard bench for ex_stall_controller: stimulus pushes hand-computed
// expected output vectors, a negedge monitor pops and compares them.
module tb_ex_stall_controller;

  // {PC_Write, IF_ID_Write, ID_EX_Write, ID_Flush, IF_Flush, EX_Flush,
  //  md_start, md_step, md_last, md_done}
  localparam logic [9:0] O_RUN     = 10'b1110000000;
  localparam logic [9:0] O_START   = 10'b0000011000;
  localparam logic [9:0] O_BUSY    = 10'b0000010100;
  localparam logic [9:0] O_LAST    = 10'b0000010110;
  localparam logic [9:0] O_DONE    = 10'b1110000001;
  localparam logic [9:0] O_DONE_BR = 10'b1110100001;
  localparam logic [9:0] O_LU      = 10'b0011000000;
  localparam logic [9:0] O_BR      = 10'b1110100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read = 1'b0;
  logic [4:0] ex_rt = 5'd0, id_rs = 5'd0, id_rt = 5'd0;
  logic muldiv = 1'b0, branch = 1'b0;
  logic b_muldiv = 1'b0, b_branch = 1'b0;

  logic [9:0]  out_a, out_b;
  logic [15:0] sc_dut_a, sc_dut_b;

  int compared = 0;
  int mismatched = 0;
  int sc_a = 0;
  int sc_b = 0;

  logic [9:0] q_a[$];
  int         q_a_sc[$];
  string      q_a_nm[$];
  logic [9:0] q_b[$];
  int         q_b_sc[$];
  string      q_b_nm[$];

  always #5 clk = ~clk;

  ex_stall_controller #(.MD_CYCLES(32), .CNT_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(mem_read), .ID_EX_Rt(ex_rt), .IF_ID_Rs(id_rs), .IF_ID_Rt(id_rt),
    .EX_MulDiv(muldiv), .branch_taken(branch),
    .PC_Write(out_a[9]), .IF_ID_Write(out_a[8]), .ID_EX_Write(out_a[7]),
    .ID_Flush(out_a[6]), .IF_Flush(out_a[5]), .EX_Flush(out_a[4]),
    .md_start(out_a[3]), .md_step(out_a[2]), .md_last(out_a[1]), .md_done(out_a[0]),
    .stall_count(sc_dut_a)
  );

  ex_stall_controller #(.MD_CYCLES(1), .CNT_W(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(1'b0), .ID_EX_Rt(5'd0), .IF_ID_Rs(5'd0), .IF_ID_Rt(5'd0),
    .EX_MulDiv(b_muldiv), .branch_taken(b_branch),
    .PC_Write(out_b[9]), .IF_ID_Write(out_b[8]), .ID_EX_Write(out_b[7]),
    .ID_Flush(out_b[6]), .IF_Flush(out_b[5]), .EX_Flush(out_b[4]),
    .md_start(out_b[3]), .md_step(out_b[2]), .md_last(out_b[1]), .md_done(out_b[0]),
    .stall_count(sc_dut_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stall_count is the number of earlier stalled cycles since reset.
  task automatic exp_a(input logic [9:0] e, input string nm);
    q_a.push_back(e);
    q_a_sc.push_back(sc_a);
    q_a_nm.push_back(nm);
    if (!e[9] && sc_a != 32'hFFFF) sc_a++;
  endtask

  task automatic exp_b(input logic [9:0] e, input string nm);
    q_b.push_back(e);
    q_b_sc.push_back(sc_b);
    q_b_nm.push_back(nm);
    if (!e[9] && sc_b != 32'hFFFF) sc_b++;
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    int s;
    string nm;
    if (q_a.size() > 0) begin
      e = q_a.pop_front(); s = q_a_sc.pop_front(); nm = q_a_nm.pop_front();
      compared++;
      if (out_a !== e) begin
        mismatched++;
        $display("FAIL %s outs(A): got %b want %b at %0t", nm, out_a, e, $time);
      end
      compared++;
      if (sc_dut_a !== 16'(s)) begin
        mismatched++;
        $display("FAIL %s stall_count(A): got %0d want %0d at %0t", nm, sc_dut_a, s, $time);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front(); s = q_b_sc.pop_front(); nm = q_b_nm.pop_front();
      compared++;
      if (out_b !== e) begin
        mismatched++;
        $display("FAIL %s outs(B): got %b want %b at %0t", nm, out_b, e, $time);
      end
      compared++;
      if (sc_dut_b !== 16'(s)) begin
        mismatched++;
        $display("FAIL %s stall_count(B): got %0d want %0d at %0t", nm, sc_dut_b, s, $time);
      end
    end
  end

  initial begin
    // Reset values
    tick(); exp_a(O_RUN, "reset");
    tick(); rst_n = 1'b1; exp_a(O_RUN, "idle");

    // 32-cycle mul/div, EX_MulDiv held high through MD_DONE
    tick(); muldiv = 1'b1; exp_a(O_START, "md_start");
    for (int i = 1; i <= 31; i++) begin
      tick(); exp_a(O_BUSY, "md_busy");
    end
    tick(); exp_a(O_LAST, "md_last");
    tick(); exp_a(O_DONE, "md_done_sc33");

    // Back-to-back op starts from RUN, then reset in its 5th busy cycle
    tick(); exp_a(O_START, "b2b_start");
    for (int i = 1; i <= 4; i++) begin
      tick(); exp_a(O_BUSY, "b2b_busy");
    end
    tick(); #2 rst_n = 1'b0; sc_a = 0; exp_a(O_RUN, "rst_mid");
    tick(); muldiv = 1'b0; exp_a(O_RUN, "rst_hold");
    tick(); rst_n = 1'b1; exp_a(O_RUN, "post_rst");
    tick(); exp_a(O_RUN, "post_rst_no_done");

    // Load-use hazards
    tick(); mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; exp_a(O_LU, "lu_rt");
    tick(); mem_read = 1'b0; exp_a(O_RUN, "lu_clear");
    tick(); mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_rt = 5'd1; exp_a(O_LU, "lu_rs");
    tick(); ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; exp_a(O_RUN, "lu_r0");
    tick(); mem_read = 1'b0; ex_rt = 5'd9; id_rs = 5'd9; exp_a(O_RUN, "no_load");
    tick(); mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd8; id_rt = 5'd10; exp_a(O_RUN, "lu_nomatch");

    // Load-use wins over branch, branch squashes next cycle
    tick(); ex_rt = 5'd4; id_rs = 5'd4; branch = 1'b1; exp_a(O_LU, "lu_and_br");
    tick(); mem_read = 1'b0; exp_a(O_BR, "br_after_lu");
    tick(); branch = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; exp_a(O_RUN, "br_clear");

    // MD_CYCLES=1 instance: 2 freeze cycles, branch held off until MD_DONE
    tick(); b_muldiv = 1'b1; exp_b(O_START, "md1_start");
    tick(); b_branch = 1'b1; exp_b(O_LAST, "md1_step_last_br");
    tick(); b_muldiv = 1'b0; exp_b(O_DONE_BR, "md1_done_br");
    tick(); b_branch = 1'b0; exp_b(O_RUN, "md1_idle_sc2");

    // Saturation: 70000+ continuous load-use stalls
    tick(); mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; exp_a(O_LU, "sat_first");
    for (int i = 0; i < 69999; i++) tick();
    sc_a = (sc_a + 69999 > 32'hFFFF) ? 32'hFFFF : sc_a + 69999;
    tick(); exp_a(O_LU, "sat_hold");
    tick(); exp_a(O_LU, "sat_hold2");
    tick(); mem_read = 1'b0; exp_a(O_RUN, "sat_release");
    tick(); exp_a(O_RUN, "sat_after");

    @(negedge clk); #1;
    compared++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", q_a.size(), q_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
